// File: rtl/wb_arbiter.sv
// Writeback merge stage: per-channel result FIFOs, a round-robin grant and one registered commit port.
// Optional macro WB_ARB_PERF_EN adds saturating conflict and full-stall counters.
module wb_arbiter #(
  parameter int NUM_CH = 4,
  parameter int DATA_W = 64,
  parameter int RD_W   = 5,
  parameter int PC_W   = 64,
  parameter int DEPTH  = 2
) (
  input  logic                       clock,
  input  logic                       reset,
  input  logic                       flush,
  input  logic [NUM_CH-1:0]          in_valid,
  output logic [NUM_CH-1:0]          in_ready,
  input  logic [NUM_CH-1:0]          in_need_to_wb,
  input  logic [NUM_CH*RD_W-1:0]     in_rd,
  input  logic [NUM_CH*DATA_W-1:0]   in_data,
  input  logic [NUM_CH*PC_W-1:0]     in_pc,
  output logic                       wb_valid,
  output logic                       wb_rfwen,
  output logic [RD_W-1:0]            wb_rd,
  output logic [DATA_W-1:0]          wb_data,
  output logic [PC_W-1:0]            wb_pc,
  output logic [$clog2(NUM_CH)-1:0]  wb_ch,
  output logic                       busy
`ifdef WB_ARB_PERF_EN
  ,
  output logic [31:0]                perf_conflict_cnt,
  output logic [31:0]                perf_full_cnt
`endif
);

  localparam int CH_W  = $clog2(NUM_CH);
  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  // Handshake: a result moves into channel i at a rising edge where in_valid[i]
  // and in_ready[i] are both high; in_ready depends only on the registered count,
  // so a full FIFO stays not-ready during the cycle it is popped.

  logic [RD_W-1:0]   r_mem_rd   [NUM_CH][DEPTH];
  logic [DATA_W-1:0] r_mem_data [NUM_CH][DEPTH];
  logic [PC_W-1:0]   r_mem_pc   [NUM_CH][DEPTH];
  logic              r_mem_need [NUM_CH][DEPTH];
  logic [PTR_W-1:0]  r_wptr     [NUM_CH];
  logic [PTR_W-1:0]  r_rptr     [NUM_CH];
  logic [CNT_W-1:0]  r_cnt      [NUM_CH];
  logic [CH_W-1:0]   r_last_grant;

  logic              r_wb_valid;
  logic              r_wb_rfwen;
  logic [RD_W-1:0]   r_wb_rd;
  logic [DATA_W-1:0] r_wb_data;
  logic [PC_W-1:0]   r_wb_pc;
  logic [CH_W-1:0]   r_wb_ch;

  logic [NUM_CH-1:0] w_req;
  logic [NUM_CH-1:0] w_push;
  logic [NUM_CH-1:0] w_pop;
  logic              w_grant;
  logic [CH_W-1:0]   w_winner;
  logic [CH_W-1:0]   w_idx_ch;
  int                w_idx;
  logic [RD_W-1:0]   w_head_rd;
  logic [DATA_W-1:0] w_head_data;
  logic [PC_W-1:0]   w_head_pc;
  logic              w_head_need;

  always_comb begin
    in_ready = '0;
    w_req    = '0;
    w_push   = '0;
    w_pop    = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      in_ready[i] = (r_cnt[i] < CNT_W'(DEPTH));
      w_req[i]    = (r_cnt[i] != '0);
      w_push[i]   = in_valid[i] & in_ready[i];
      w_pop[i]    = w_grant && (w_winner == CH_W'(i));
    end
  end

  // Scan from the lowest priority (last_grant) toward the highest so the
  // closest requester after last_grant is the final assignment.
  always_comb begin
    w_grant  = 1'b0;
    w_winner = '0;
    w_idx    = 0;
    w_idx_ch = '0;
    for (int k = NUM_CH; k >= 1; k--) begin
      w_idx    = (int'(r_last_grant) + k) % NUM_CH;
      w_idx_ch = CH_W'(w_idx);
      if (w_req[w_idx_ch]) begin
        w_grant  = 1'b1;
        w_winner = w_idx_ch;
      end
    end
  end

  assign w_head_rd   = r_mem_rd[w_winner][r_rptr[w_winner]];
  assign w_head_data = r_mem_data[w_winner][r_rptr[w_winner]];
  assign w_head_pc   = r_mem_pc[w_winner][r_rptr[w_winner]];
  assign w_head_need = r_mem_need[w_winner][r_rptr[w_winner]];

  always_ff @(posedge clock) begin
    for (int i = 0; i < NUM_CH; i++) begin
      if (w_push[i] && !reset && !flush) begin
        r_mem_rd[i][r_wptr[i]]   <= in_rd[i*RD_W +: RD_W];
        r_mem_data[i][r_wptr[i]] <= in_data[i*DATA_W +: DATA_W];
        r_mem_pc[i][r_wptr[i]]   <= in_pc[i*PC_W +: PC_W];
        r_mem_need[i][r_wptr[i]] <= in_need_to_wb[i];
      end
    end
  end

  always_ff @(posedge clock) begin
    for (int i = 0; i < NUM_CH; i++) begin
      if (reset || flush) begin
        r_wptr[i] <= '0;
        r_rptr[i] <= '0;
        r_cnt[i]  <= '0;
      end else begin
        if (w_push[i]) r_wptr[i] <= r_wptr[i] + 1'b1;
        if (w_pop[i])  r_rptr[i] <= r_rptr[i] + 1'b1;
        r_cnt[i] <= r_cnt[i] + CNT_W'(w_push[i]) - CNT_W'(w_pop[i]);
      end
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      r_last_grant <= CH_W'(NUM_CH - 1);
      r_wb_valid   <= 1'b0;
      r_wb_rfwen   <= 1'b0;
      r_wb_rd      <= '0;
      r_wb_data    <= '0;
      r_wb_pc      <= '0;
      r_wb_ch      <= '0;
    end else if (flush) begin
      r_wb_valid <= 1'b0;
      r_wb_rfwen <= 1'b0;
    end else begin
      r_wb_valid <= w_grant;
      r_wb_rfwen <= w_grant & w_head_need & (w_head_rd != '0);
      if (w_grant) begin
        r_last_grant <= w_winner;
        r_wb_rd      <= w_head_rd;
        r_wb_data    <= w_head_data;
        r_wb_pc      <= w_head_pc;
        r_wb_ch      <= w_winner;
      end
    end
  end

  assign wb_valid = r_wb_valid;
  assign wb_rfwen = r_wb_rfwen;
  assign wb_rd    = r_wb_rd;
  assign wb_data  = r_wb_data;
  assign wb_pc    = r_wb_pc;
  assign wb_ch    = r_wb_ch;
  assign busy     = (|w_req) | r_wb_valid;

`ifdef WB_ARB_PERF_EN
  logic [31:0] r_perf_conflict;
  logic [31:0] r_perf_full;
  logic        w_conflict_evt;
  logic        w_full_evt;

  assign w_conflict_evt = ($countones(w_req) > 1);
  assign w_full_evt     = |(in_valid & ~in_ready);

  // Counters saturate and survive flush; only reset clears them.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_perf_conflict <= '0;
      r_perf_full     <= '0;
    end else begin
      if (w_conflict_evt && (r_perf_conflict != '1)) r_perf_conflict <= r_perf_conflict + 1'b1;
      if (w_full_evt && (r_perf_full != '1))         r_perf_full     <= r_perf_full + 1'b1;
    end
  end

  assign perf_conflict_cnt = r_perf_conflict;
  assign perf_full_cnt     = r_perf_full;
`endif

endmodule

// File: tb/tb_wb_arbiter.sv
// Bench for wb_arbiter: queue-based reference model compared every cycle, plus directed literal checks.
module tb_wb_arbiter;
  localparam int NUM_CH = 4;
  localparam int DATA_W = 64;
  localparam int RD_W   = 5;
  localparam int PC_W   = 64;
  localparam int DEPTH  = 2;
  localparam int CH_W   = 2;

  logic                     clock = 1'b0;
  logic                     reset;
  logic                     flush;
  logic [NUM_CH-1:0]        in_valid;
  logic [NUM_CH-1:0]        in_ready;
  logic [NUM_CH-1:0]        in_need_to_wb;
  logic [NUM_CH*RD_W-1:0]   in_rd;
  logic [NUM_CH*DATA_W-1:0] in_data;
  logic [NUM_CH*PC_W-1:0]   in_pc;
  logic                     wb_valid;
  logic                     wb_rfwen;
  logic [RD_W-1:0]          wb_rd;
  logic [DATA_W-1:0]        wb_data;
  logic [PC_W-1:0]          wb_pc;
  logic [CH_W-1:0]          wb_ch;
  logic                     busy;
`ifdef WB_ARB_PERF_EN
  logic [31:0]              perf_conflict_cnt;
  logic [31:0]              perf_full_cnt;
`endif

  always #5 clock = ~clock;

  wb_arbiter #(.NUM_CH(NUM_CH), .DATA_W(DATA_W), .RD_W(RD_W), .PC_W(PC_W), .DEPTH(DEPTH)) dut (
    .clock(clock), .reset(reset), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_need_to_wb(in_need_to_wb),
    .in_rd(in_rd), .in_data(in_data), .in_pc(in_pc),
    .wb_valid(wb_valid), .wb_rfwen(wb_rfwen), .wb_rd(wb_rd), .wb_data(wb_data),
    .wb_pc(wb_pc), .wb_ch(wb_ch), .busy(busy)
`ifdef WB_ARB_PERF_EN
    , .perf_conflict_cnt(perf_conflict_cnt), .perf_full_cnt(perf_full_cnt)
`endif
  );

  int total = 0;
  int bad   = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s act=%h exp=%h t=%0t", nm, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  typedef struct packed {
    logic              need;
    logic [RD_W-1:0]   rd;
    logic [DATA_W-1:0] data;
    logic [PC_W-1:0]   pc;
  } ent_t;

  ent_t              mq [NUM_CH][$];
  int                m_last;
  logic              m_init = 1'b0;
  logic              e_valid, e_rfwen;
  logic [RD_W-1:0]   e_rd;
  logic [DATA_W-1:0] e_data;
  logic [PC_W-1:0]   e_pc;
  int                e_ch;
  longint            m_conf, m_full;
  int                m_nreq, m_win, m_c;
  logic              m_anyfull, m_found;
  logic [NUM_CH-1:0] m_rdy;
  ent_t              m_e;

  always @(posedge clock) begin
    m_nreq = 0;
    m_anyfull = 1'b0;
    for (int i = 0; i < NUM_CH; i++) begin
      m_rdy[i] = (mq[i].size() < DEPTH);
      if (mq[i].size() > 0) m_nreq++;
      if (in_valid[i] && !m_rdy[i]) m_anyfull = 1'b1;
    end
    if (reset) begin
      for (int i = 0; i < NUM_CH; i++) mq[i].delete();
      m_last = NUM_CH - 1;
      e_valid = 0; e_rfwen = 0; e_rd = 0; e_data = 0; e_pc = 0; e_ch = 0;
      m_conf = 0; m_full = 0;
      m_init = 1'b1;
    end else begin
      if (m_nreq > 1 && m_conf < 64'hFFFF_FFFF) m_conf++;
      if (m_anyfull && m_full < 64'hFFFF_FFFF) m_full++;
      if (flush) begin
        for (int i = 0; i < NUM_CH; i++) mq[i].delete();
        e_valid = 0; e_rfwen = 0;
      end else begin
        m_found = 1'b0;
        m_win = 0;
        for (int k = 1; k <= NUM_CH; k++) begin
          m_c = (m_last + k) % NUM_CH;
          if (!m_found && mq[m_c].size() > 0) begin m_found = 1'b1; m_win = m_c; end
        end
        e_valid = m_found;
        e_rfwen = 1'b0;
        if (m_found) begin
          m_e = mq[m_win].pop_front();
          m_last = m_win;
          e_rd = m_e.rd; e_data = m_e.data; e_pc = m_e.pc; e_ch = m_win;
          e_rfwen = m_e.need && (m_e.rd != 0);
        end
        for (int i = 0; i < NUM_CH; i++)
          if (in_valid[i] && m_rdy[i])
            mq[i].push_back({in_need_to_wb[i], in_rd[i*RD_W +: RD_W],
                             in_data[i*DATA_W +: DATA_W], in_pc[i*PC_W +: PC_W]});
      end
    end
  end

  logic [NUM_CH-1:0] x_rdy;
  logic              x_busy;
  always @(negedge clock) begin
    if (m_init) begin
      x_busy = e_valid;
      for (int i = 0; i < NUM_CH; i++) begin
        x_rdy[i] = (mq[i].size() < DEPTH);
        if (mq[i].size() > 0) x_busy = 1'b1;
      end
      chk("wb_valid", wb_valid, e_valid);
      chk("wb_rfwen", wb_rfwen, e_rfwen);
      chk("wb_rd", wb_rd, e_rd);
      chk("wb_data", wb_data, e_data);
      chk("wb_pc", wb_pc, e_pc);
      chk("wb_ch", wb_ch, e_ch);
      chk("in_ready", in_ready, x_rdy);
      chk("busy", busy, x_busy);
`ifdef WB_ARB_PERF_EN
      chk("perf_conflict", perf_conflict_cnt, m_conf);
      chk("perf_full", perf_full_cnt, m_full);
`endif
    end
  end

  // ---------------- driver ----------------
  task automatic step();
    @(posedge clock);
    #2;
  endtask

  task automatic set_ch(input int i, input logic v, input logic need, input logic [RD_W-1:0] rd,
                        input logic [DATA_W-1:0] data, input logic [PC_W-1:0] pc);
    in_valid[i]                 = v;
    in_need_to_wb[i]            = need;
    in_rd[i*RD_W +: RD_W]       = rd;
    in_data[i*DATA_W +: DATA_W] = data;
    in_pc[i*PC_W +: PC_W]       = pc;
  endtask

  task automatic clr_inputs();
    in_valid = '0; in_need_to_wb = '0; in_rd = '0; in_data = '0; in_pc = '0; flush = 1'b0;
  endtask

  task automatic do_reset();
    clr_inputs();
    reset = 1'b1;
    step();
    reset = 1'b0;
  endtask

  logic [DATA_W-1:0] vals [4];
  logic [DATA_W-1:0] got_q [$];
  logic [NUM_CH-1:0] hold;
  int sent, lows, bad3;
  logic hs0;

  initial begin
    clr_inputs();
    reset = 1'b1;
    step();
    chk("rst_wb_valid", wb_valid, 0);
    chk("rst_in_ready", in_ready, 4'hF);
    chk("rst_wb_ch", wb_ch, 0);
    chk("rst_busy", busy, 0);
    reset = 1'b0;

    // single channel latency
    set_ch(2, 1, 1, 5'd5, 64'hDEAD, 64'h8000_0000);
    step();
    set_ch(2, 0, 0, 0, 0, 0);
    step();
    chk("sc_valid", wb_valid, 1);
    chk("sc_ch", wb_ch, 2);
    chk("sc_rfwen", wb_rfwen, 1);
    chk("sc_data", wb_data, 64'hDEAD);
    chk("sc_pc", wb_pc, 64'h8000_0000);
    step();
    chk("sc_busy_after", busy, 0);

    // round robin
    do_reset();
    for (int i = 0; i < NUM_CH; i++) set_ch(i, 1, 1, 5'(i + 1), 64'h100 + 64'(i), 64'h0);
    step();
    clr_inputs();
    for (int i = 0; i < NUM_CH; i++) begin
      step();
      chk("rr_ch", wb_ch, i);
      chk("rr_valid", wb_valid, 1);
    end
    set_ch(1, 1, 1, 5'd9, 64'h201, 0);
    set_ch(3, 1, 1, 5'd9, 64'h203, 0);
    step();
    clr_inputs();
    step();
    chk("rr2_first", wb_ch, 1);
    step();
    chk("rr2_second", wb_ch, 3);

    // backpressure on ch0 while ch1 stays busy
    do_reset();
    for (int k = 0; k < 4; k++) vals[k] = 64'hC0DE_0000_0000_0000 + 64'(k * 17 + 3);
    sent = 0; lows = 0;
    got_q.delete();
    for (int cyc = 0; cyc < 60 && got_q.size() < 4; cyc++) begin
      if (sent < 4) set_ch(0, 1, 1, 5'd7, vals[sent], 64'h40);
      else          set_ch(0, 0, 0, 0, 0, 0);
      set_ch(1, 1, 1, 5'd3, 64'h1111, 64'h44);
      hs0 = in_valid[0] & in_ready[0];
      if (!in_ready[0]) lows++;
      step();
      if (hs0) sent++;
      if (wb_valid && wb_ch == 0) got_q.push_back(wb_data);
    end
    clr_inputs();
    chk("bp_count", got_q.size(), 4);
    for (int k = 0; k < 4; k++) chk("bp_order", (k < got_q.size()) ? got_q[k] : 64'hX, vals[k]);
    chk("bp_ready_dropped", (lows != 0), 1);
    repeat (6) step();

    // write to x0
    set_ch(1, 1, 1, 5'd0, 64'h1234, 64'h88);
    step();
    clr_inputs();
    step();
    chk("x0_valid", wb_valid, 1);
    chk("x0_rfwen", wb_rfwen, 0);
    chk("x0_rd", wb_rd, 0);
    chk("x0_data", wb_data, 64'h1234);

    // flush with a coincident push
    do_reset();
    set_ch(1, 1, 1, 5'd1, 64'hA1, 0);
    set_ch(2, 1, 1, 5'd2, 64'hA2, 0);
    step();
    set_ch(1, 1, 1, 5'd1, 64'hB1, 0);
    set_ch(2, 1, 1, 5'd2, 64'hB2, 0);
    step();
    clr_inputs();
    set_ch(3, 1, 1, 5'd3, 64'hBAD3, 0);
    flush = 1'b1;
    step();
    clr_inputs();
    chk("fl_valid", wb_valid, 0);
    chk("fl_busy", busy, 0);
    chk("fl_ready", in_ready, 4'hF);
    bad3 = 0;
    repeat (5) begin
      step();
      if (wb_valid && wb_data == 64'hBAD3) bad3++;
    end
    chk("fl_ch3_gone", bad3, 0);

`ifdef WB_ARB_PERF_EN
    do_reset();
    for (int i = 0; i < NUM_CH; i++) set_ch(i, 1, 0, 5'd1, 64'h300 + 64'(i), 0);
    step();
    clr_inputs();
    set_ch(0, 1, 0, 5'd1, 64'h310, 0);
    set_ch(1, 1, 0, 5'd1, 64'h311, 0);
    step();
    clr_inputs();
    repeat (6) step();
    chk("perf_conf5", perf_conflict_cnt, 5);
    flush = 1'b1;
    step();
    flush = 1'b0;
    chk("perf_conf_flush", perf_conflict_cnt, 5);
    do_reset();
    chk("perf_conf_rst", perf_conflict_cnt, 0);
`endif

    // randomized traffic with occasional flush and reset
    do_reset();
    hold = '0;
    for (int c = 0; c < 3000; c++) begin
      for (int i = 0; i < NUM_CH; i++)
        if (!hold[i])
          set_ch(i, ($urandom_range(0, 99) < 60), $urandom_range(0, 1), 5'($urandom_range(0, 31)),
                 {$urandom, $urandom}, {$urandom, $urandom});
      flush = ($urandom_range(0, 49) == 0);
      reset = ($urandom_range(0, 299) == 0);
      hold = in_valid & ~in_ready;
      step();
    end
    clr_inputs();
    reset = 1'b0;
    repeat (8) step();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
